// File: rtl/sram22_ctrl_pkg.sv
// rtl/sram22_ctrl_pkg.sv - shared widths, controller states and request record for the SRAM22 port
package sram22_ctrl_pkg;

  localparam int SRAM22_DATA_WIDTH = 22;
  localparam int SRAM22_ADDR_WIDTH = 6;

  typedef enum logic [1:0] {
    WAKE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2
  } ctrl_state_e;

  typedef struct packed {
    logic                         we;
    logic [SRAM22_ADDR_WIDTH-1:0] addr;
    logic [SRAM22_DATA_WIDTH-1:0] din;
  } sram22_req_t;

endpackage

// File: rtl/sram22_rsp_fifo.sv
// rtl/sram22_rsp_fifo.sv - small power-of-two response queue with head, count, full and empty
module sram22_rsp_fifo #(
  parameter int WIDTH = 22,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rstb,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_COUNT = DEPTH[PTR_W:0];

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == FULL_COUNT);
  assign count   = count_q;
  assign head    = mem_q[rd_ptr_q];
  assign do_pop  = pop && !empty;
  // A push into a full queue is only accepted when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);

  // Storage, pointers and occupancy; pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      if (do_push && !do_pop) begin
        count_q <= count_q + (PTR_W+1)'(1);
      end else if (!do_push && do_pop) begin
        count_q <= count_q - (PTR_W+1)'(1);
      end
    end
  end

endmodule

// File: rtl/sram22_port_ctrl.sv
// rtl/sram22_port_ctrl.sv - ready/valid request port, wake/clear sequencing and pin muxing for the SRAM22 macro
module sram22_port_ctrl
  import sram22_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = SRAM22_DATA_WIDTH,
  parameter int ADDR_WIDTH = SRAM22_ADDR_WIDTH,
  parameter int RSP_DEPTH  = 4,
  parameter bit INIT_CLEAR = 1'b1
) (
  input  logic                  clk,
  input  logic                  rstb,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_din,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_dout,
  output logic                  init_done,
  output logic                  sram_rstb,
  output logic                  sram_ce,
  output logic                  sram_we,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0] sram_din,
  input  logic [DATA_WIDTH-1:0] sram_dout
);

  localparam int CNT_W = $clog2(RSP_DEPTH) + 1;
  localparam logic [CNT_W:0] CREDIT_LIMIT = RSP_DEPTH[CNT_W:0];

  ctrl_state_e           state_q;
  logic [ADDR_WIDTH-1:0] clr_cnt_q;
  logic                  sram_rstb_q;
  logic                  init_done_q;
  logic                  rd_pending_q;
  logic [ADDR_WIDTH-1:0] addr_hold_q;
  logic [DATA_WIDTH-1:0] din_hold_q;

  logic [CNT_W-1:0]      fifo_count;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [CNT_W:0]        credit_used;
  logic                  req_hs;
  logic                  rsp_pop;

  // Every outstanding read (queued or still in the macro) holds one queue slot.
  assign credit_used = {1'b0, fifo_count} + {{CNT_W{1'b0}}, rd_pending_q};
  assign req_ready   = (state_q == RUN) && (credit_used < CREDIT_LIMIT);
  assign req_hs      = req_valid && req_ready;
  assign rsp_valid   = !fifo_empty;
  assign rsp_pop     = rsp_valid && rsp_ready;
  assign init_done   = init_done_q;
  assign sram_rstb   = sram_rstb_q;

  // Wake/clear/run sequencer: releases the macro reset, optionally zero-fills, then opens the port.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q     <= WAKE;
      clr_cnt_q   <= '0;
      sram_rstb_q <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      case (state_q)
        WAKE: begin
          sram_rstb_q <= 1'b1;
          state_q     <= INIT_CLEAR ? CLEAR : RUN;
          init_done_q <= ~INIT_CLEAR;
        end
        CLEAR: begin
          clr_cnt_q <= clr_cnt_q + ADDR_WIDTH'(1);
          if (clr_cnt_q == '1) begin
            state_q     <= RUN;
            init_done_q <= 1'b1;
          end
        end
        RUN: begin
          state_q <= RUN;
        end
        default: begin
          state_q <= WAKE;
        end
      endcase
    end
  end

  // Macro pins: clear writes, pass-through on a handshake, otherwise idle with address/data held.
  always_comb begin
    sram_ce   = 1'b0;
    sram_we   = 1'b0;
    sram_addr = addr_hold_q;
    sram_din  = din_hold_q;
    if (state_q == CLEAR) begin
      sram_ce   = 1'b1;
      sram_we   = 1'b1;
      sram_addr = clr_cnt_q;
      sram_din  = '0;
    end else if (req_hs) begin
      sram_ce   = 1'b1;
      sram_we   = req_we;
      sram_addr = req_addr;
      sram_din  = req_din;
    end
  end

  // Remember the last driven address/data so idle cycles keep the macro inputs quiet.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      addr_hold_q <= '0;
      din_hold_q  <= '0;
    end else if (sram_ce) begin
      addr_hold_q <= sram_addr;
      din_hold_q  <= sram_din;
    end
  end

  // A read accepted this edge has its data on sram_dout during the following cycle.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      rd_pending_q <= 1'b0;
    end else begin
      rd_pending_q <= req_hs && !req_we;
    end
  end

  // The credit check must never let a returning read land in a full queue.
  always_ff @(posedge clk) begin
    if (rstb) begin
      assert (!(rd_pending_q && fifo_full && !rsp_pop))
        else $error("sram22_port_ctrl: response push into a full queue");
    end
  end

  sram22_rsp_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk       (clk),
    .rstb      (rstb),
    .push      (rd_pending_q),
    .push_data (sram_dout),
    .pop       (rsp_pop),
    .head      (rsp_dout),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_sram22_port_ctrl.sv
// tb/tb_sram22_port_ctrl.sv - self-checking bench for sram22_port_ctrl with a behavioural macro and scoreboard
module tb_sram22_port_ctrl;
  import sram22_ctrl_pkg::*;

  localparam int RSP_DEPTH = 4;

  logic        clk = 1'b0;
  logic        rstb;
  logic        req_valid, req_ready, req_we;
  logic [5:0]  req_addr;
  logic [21:0] req_din;
  logic        rsp_valid, rsp_ready;
  logic [21:0] rsp_dout;
  logic        init_done, sram_rstb, sram_ce, sram_we;
  logic [5:0]  sram_addr;
  logic [21:0] sram_din;

  logic        nc_req_valid, nc_req_ready, nc_req_we;
  logic [5:0]  nc_req_addr;
  logic [21:0] nc_req_din;
  logic        nc_rsp_valid, nc_rsp_ready;
  logic [21:0] nc_rsp_dout;
  logic        nc_init_done, nc_sram_rstb, nc_sram_ce, nc_sram_we;
  logic [5:0]  nc_sram_addr;
  logic [21:0] nc_sram_din;
  logic [21:0] nc_sram_dout;

  logic [21:0] macro_mem [64];
  logic [21:0] macro_dout = '0;
  logic        macro_preload;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          stall_cnt = 0;
  int          pop_total = 0;
  int          first_pop_cyc = -1;
  int          last_pop_cyc  = -1;
  logic        mon_en;
  logic [21:0] shadow [64];
  logic [21:0] exp_q [$];

  typedef struct packed {
    sram22_req_t req;
    logic [21:0] exp;
  } vec_t;

  always #5 clk = ~clk;

  sram22_port_ctrl #(.RSP_DEPTH(RSP_DEPTH), .INIT_CLEAR(1'b1)) dut (
    .clk(clk), .rstb(rstb),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_din(req_din),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dout(rsp_dout),
    .init_done(init_done), .sram_rstb(sram_rstb), .sram_ce(sram_ce), .sram_we(sram_we),
    .sram_addr(sram_addr), .sram_din(sram_din), .sram_dout(macro_dout)
  );

  sram22_port_ctrl #(.RSP_DEPTH(RSP_DEPTH), .INIT_CLEAR(1'b0)) dut_nc (
    .clk(clk), .rstb(rstb),
    .req_valid(nc_req_valid), .req_ready(nc_req_ready), .req_we(nc_req_we),
    .req_addr(nc_req_addr), .req_din(nc_req_din),
    .rsp_valid(nc_rsp_valid), .rsp_ready(nc_rsp_ready), .rsp_dout(nc_rsp_dout),
    .init_done(nc_init_done), .sram_rstb(nc_sram_rstb), .sram_ce(nc_sram_ce), .sram_we(nc_sram_we),
    .sram_addr(nc_sram_addr), .sram_din(nc_sram_din), .sram_dout(nc_sram_dout)
  );

  // Behavioural 64x22 macro: registered read, write on ce&we, inert while its reset pin is low.
  always @(posedge clk) begin
    if (macro_preload) begin
      for (int i = 0; i < 64; i++) macro_mem[i] <= 22'h3FFFFF;
    end else if (sram_rstb && sram_ce) begin
      if (sram_we) macro_mem[sram_addr] <= sram_din;
      else         macro_dout <= macro_mem[sram_addr];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard: outstanding reads are a queue of expected words; credit rule is queue size < depth.
  task automatic monitor();
    logic [21:0] e;
    if (!mon_en) return;
    check("credit_ready", 32'(req_ready), 32'(exp_q.size() < RSP_DEPTH));
    if (rsp_valid && rsp_ready) begin
      pop_total++;
      if (first_pop_cyc < 0) first_pop_cyc = cyc;
      last_pop_cyc = cyc;
      if (exp_q.size() == 0) check("unexpected_rsp", 32'(1), 32'(0));
      else begin
        e = exp_q.pop_front();
        check("rsp_dout", 32'(rsp_dout), 32'(e));
      end
    end
    if (req_valid && req_ready) begin
      if (req_we) shadow[req_addr] = req_din;
      else        exp_q.push_back(shadow[req_addr]);
    end
  endtask

  task automatic at_neg();
    @(negedge clk);
    monitor();
  endtask

  task automatic to_pos();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) shadow[i] = '0;
    exp_q.delete();
    mon_en = 1'b1;
  endtask

  task automatic issue(input logic we, input logic [5:0] a, input logic [21:0] d, output int hc);
    req_valid = 1'b1; req_we = we; req_addr = a; req_din = d; hc = -1;
    for (int w = 0; w < 40 && hc < 0; w++) begin
      at_neg();
      if (req_ready) hc = cyc;
      else stall_cnt++;
      to_pos();
    end
    req_valid = 1'b0;
    if (hc < 0) check("issue_timeout", 32'(0), 32'(1));
  endtask

  task automatic drain();
    int w = 0;
    rsp_ready = 1'b1;
    while ((exp_q.size() != 0 || rsp_valid) && w < 60) begin
      at_neg(); to_pos(); w++;
    end
    check("drain_empty", 32'(exp_q.size()), 32'(0));
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_req_ready"}, 32'(req_ready), 32'(0));
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'(0));
    check({tag, "_rsp_dout"},  32'(rsp_dout),  32'(0));
    check({tag, "_init_done"}, 32'(init_done), 32'(0));
    check({tag, "_sram_rstb"}, 32'(sram_rstb), 32'(0));
    check({tag, "_sram_ce"},   32'(sram_ce),   32'(0));
    check({tag, "_sram_we"},   32'(sram_we),   32'(0));
    check({tag, "_sram_addr"}, 32'(sram_addr), 32'(0));
    check({tag, "_sram_din"},  32'(sram_din),  32'(0));
  endtask

  // Called just after reset release: walks edges 1..65 and the first RUN cycle.
  task automatic check_clear();
    int errs = 0;
    int nc_ce = 0;
    int nz = 0;
    for (int e = 1; e <= 66; e++) begin
      at_neg();
      if (nc_sram_ce) nc_ce++;
      if (e == 1) begin
        check("wake_sram_rstb", 32'(sram_rstb), 32'(0));
        check("wake_sram_ce", 32'(sram_ce), 32'(0));
        check("nc_init_before_edge1", 32'(nc_init_done), 32'(0));
      end else if (e <= 65) begin
        if (e == 2) begin
          check("nc_init_after_edge1", 32'(nc_init_done), 32'(1));
          check("nc_ready_after_edge1", 32'(nc_req_ready), 32'(1));
        end
        if (sram_ce !== 1'b1 || sram_we !== 1'b1 || sram_addr !== 6'(e - 2) || sram_din !== 22'h0 ||
            req_ready !== 1'b0 || init_done !== 1'b0 || sram_rstb !== 1'b1 || rsp_valid !== 1'b0)
          errs++;
      end else begin
        check("init_done_after_65", 32'(init_done), 32'(1));
        check("ready_after_65", 32'(req_ready), 32'(1));
        check("ce_idle_after_clear", 32'(sram_ce), 32'(0));
      end
      to_pos();
    end
    check("clear_bad_cycles", 32'(errs), 32'(0));
    check("nc_ce_during_clear", 32'(nc_ce), 32'(0));
    for (int i = 0; i < 64; i++) if (macro_mem[i] !== 22'h0) nz++;
    check("macro_nonzero_words", 32'(nz), 32'(0));
  endtask

  function automatic vec_t mk(input logic we, input logic [5:0] a, input logic [21:0] d, input logic [21:0] e);
    vec_t v;
    v.req.we = we; v.req.addr = a; v.req.din = d; v.exp = e;
    return v;
  endfunction

  initial begin
    vec_t vecs [12];
    int   hc, c0, got, base, acc;

    vecs[0]  = mk(1'b0, 6'd0,  22'h0,      22'h0);
    vecs[1]  = mk(1'b0, 6'd31, 22'h0,      22'h0);
    vecs[2]  = mk(1'b0, 6'd63, 22'h0,      22'h0);
    vecs[3]  = mk(1'b1, 6'd5,  22'h15A5A5, 22'h0);
    vecs[4]  = mk(1'b0, 6'd5,  22'h0,      22'h15A5A5);
    vecs[5]  = mk(1'b1, 6'd0,  22'h000001, 22'h0);
    vecs[6]  = mk(1'b1, 6'd63, 22'h3FFFFF, 22'h0);
    vecs[7]  = mk(1'b0, 6'd63, 22'h0,      22'h3FFFFF);
    vecs[8]  = mk(1'b0, 6'd0,  22'h0,      22'h000001);
    vecs[9]  = mk(1'b1, 6'd31, 22'h2AAAAA, 22'h0);
    vecs[10] = mk(1'b0, 6'd31, 22'h0,      22'h2AAAAA);
    vecs[11] = mk(1'b0, 6'd5,  22'h0,      22'h15A5A5);

    rstb = 1'b0; mon_en = 1'b0; macro_preload = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_din = '0; rsp_ready = 1'b1;
    nc_req_valid = 1'b0; nc_req_we = 1'b0; nc_req_addr = '0; nc_req_din = '0; nc_rsp_ready = 1'b1;
    nc_sram_dout = 22'h0ABCDE;
    to_pos(); to_pos(); to_pos();
    macro_preload = 1'b0;
    at_neg();
    check_reset_values("reset");
    to_pos();

    rstb = 1'b1;
    check_clear();
    model_reset();

    // INIT_CLEAR=0 instance: one write then one read through the port
    nc_req_valid = 1'b1; nc_req_we = 1'b1; nc_req_addr = 6'd9; nc_req_din = 22'h000123;
    at_neg();
    check("nc_ready", 32'(nc_req_ready), 32'(1));
    check("nc_ce_on_req", 32'(nc_sram_ce), 32'(1));
    check("nc_we_on_req", 32'(nc_sram_we), 32'(1));
    check("nc_addr_on_req", 32'(nc_sram_addr), 32'(9));
    check("nc_din_on_req", 32'(nc_sram_din), 32'(22'h000123));
    check("nc_sram_rstb", 32'(nc_sram_rstb), 32'(1));
    to_pos();
    nc_req_we = 1'b0;
    at_neg(); to_pos();
    nc_req_valid = 1'b0;
    at_neg(); check("nc_rsp_early", 32'(nc_rsp_valid), 32'(0)); to_pos();
    at_neg();
    check("nc_rsp_valid", 32'(nc_rsp_valid), 32'(1));
    check("nc_rsp_dout", 32'(nc_rsp_dout), 32'(22'h0ABCDE));
    to_pos();

    // Directed vector table with pin and latency checks
    for (int i = 0; i < 12; i++) begin
      req_valid = 1'b1; req_we = vecs[i].req.we; req_addr = vecs[i].req.addr;
      req_din = vecs[i].req.we ? vecs[i].req.din : 22'($urandom);
      got = 0;
      for (int w = 0; w < 20 && got == 0; w++) begin
        at_neg();
        if (req_ready) begin
          got = 1;
          check("vec_ce", 32'(sram_ce), 32'(1));
          check("vec_we", 32'(sram_we), 32'(vecs[i].req.we));
          check("vec_addr", 32'(sram_addr), 32'(vecs[i].req.addr));
          if (vecs[i].req.we) check("vec_din", 32'(sram_din), 32'(vecs[i].req.din));
        end
        to_pos();
      end
      if (got == 0) check("vec_handshake", 32'(0), 32'(1));
      req_valid = 1'b0;
      if (!vecs[i].req.we) begin
        at_neg();
        check("vec_lat1_valid", 32'(rsp_valid), 32'(0));
        check("vec_idle_ce", 32'(sram_ce), 32'(0));
        check("vec_hold_addr", 32'(sram_addr), 32'(vecs[i].req.addr));
        to_pos();
        at_neg();
        check("vec_lat2_valid", 32'(rsp_valid), 32'(1));
        check("vec_rdata", 32'(rsp_dout), 32'(vecs[i].exp));
        to_pos();
      end
    end
    drain();

    // Streaming: data = address, then 16 back-to-back reads with rsp_ready=1
    for (int i = 0; i < 16; i++) issue(1'b1, 6'(i), 22'(i), hc);
    stall_cnt = 0; pop_total = 0; first_pop_cyc = -1; c0 = -1;
    for (int i = 0; i < 16; i++) begin
      issue(1'b0, 6'(i), 22'h0, hc);
      if (i == 0) c0 = hc;
    end
    drain();
    check("stream_stalls", 32'(stall_cnt), 32'(0));
    check("stream_pops", 32'(pop_total), 32'(16));
    check("stream_first_latency", 32'(first_pop_cyc - c0), 32'(2));
    check("stream_last_offset", 32'(last_pop_cyc - c0), 32'(17));

    // Back-pressure: four reads fill the credits, the fifth must wait
    rsp_ready = 1'b0; stall_cnt = 0; pop_total = 0;
    for (int i = 0; i < 4; i++) issue(1'b0, 6'(i), 22'h0, hc);
    check("bp_first4_stalls", 32'(stall_cnt), 32'(0));
    req_valid = 1'b1; req_we = 1'b0; req_addr = 6'd4; acc = 0;
    for (int w = 0; w < 8; w++) begin
      at_neg();
      if (req_ready) acc++;
      to_pos();
    end
    check("bp_ready_low_when_full", 32'(acc), 32'(0));
    check("bp_rsp_held", 32'(rsp_valid), 32'(1));
    rsp_ready = 1'b1;
    for (int i = 4; i < 16; i++) issue(1'b0, 6'(i), 22'h0, hc);
    drain();
    check("bp_pops", 32'(pop_total), 32'(16));

    // Random traffic against the scoreboard
    base = pop_total;
    for (int r = 0; r < 400; r++) begin
      req_valid = ($urandom_range(0, 3) != 0);
      req_we    = ($urandom_range(0, 1) == 1);
      req_addr  = 6'($urandom_range(0, 15));
      req_din   = 22'($urandom);
      rsp_ready = ($urandom_range(0, 2) != 0);
      at_neg(); to_pos();
    end
    req_valid = 1'b0;
    drain();
    check("random_pops_seen", 32'(pop_total > base), 32'(1));

    // Asynchronous reset with one response queued and one read in the macro
    rsp_ready = 1'b0;
    issue(1'b0, 6'd1, 22'h0, hc);
    issue(1'b0, 6'd2, 22'h0, hc);
    check("pre_reset_rsp_queued", 32'(rsp_valid), 32'(1));
    req_valid = 1'b1; req_we = 1'b0; req_addr = 6'd3;
    #2 rstb = 1'b0;
    #1;
    check_reset_values("async_reset");
    mon_en = 1'b0; exp_q.delete(); req_valid = 1'b0;
    macro_preload = 1'b1;
    to_pos();
    macro_preload = 1'b0;
    at_neg();
    check("reset_hold_rsp_valid", 32'(rsp_valid), 32'(0));
    to_pos();
    rstb = 1'b1;
    check_clear();
    model_reset();
    issue(1'b0, 6'd1, 22'h0, hc);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
